// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU (C)
// and an external loader/debug port (X); each access runs IDLE -> ACCESS -> RESP.
module dmem_arbiter #(
    parameter int AW     = 64,
    parameter int DW     = 64,
    parameter int RD_LAT = 1
) (
    input  logic          CLK,
    input  logic          resetl,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic [DW-1:0] c_rdata,
    output logic          cpu_stall,
    input  logic          x_req,
    input  logic          x_we,
    input  logic [AW-1:0] x_addr,
    input  logic [DW-1:0] x_wdata,
    output logic          x_ack,
    output logic [DW-1:0] x_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(RD_LAT);

    state_t        state_q, state_d;
    logic          own_q;      // 0 = C, 1 = X
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          rr_last_q;  // requester served most recently
    logic [3:0]    cnt_q;
    logic          grant_x;

    // On a tie the requester that was not served last wins.
    assign grant_x   = x_req & (~c_req | ~rr_last_q);
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (c_req || x_req) state_d = ACCESS;
            ACCESS:  if (we_q || cnt_q == 4'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reads hold mem_read for RD_LAT cycles, then spend one more ACCESS cycle
    // with the strobe low while the returned data is captured.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        c_ack     = 1'b0;
        x_ack     = 1'b0;
        if (state_q == ACCESS) begin
            mem_write = we_q;
            mem_read  = ~we_q & (cnt_q != 4'd0);
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end
        if (state_q == RESP) begin
            c_ack = ~own_q;
            x_ack = own_q;
        end
        cpu_stall = c_req & ~c_ack;
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q   <= IDLE;
            own_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rr_last_q <= 1'b1;
            cnt_q     <= 4'd0;
            c_rdata   <= '0;
            x_rdata   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (c_req || x_req) begin
                        own_q   <= grant_x;
                        we_q    <= grant_x ? x_we    : c_we;
                        addr_q  <= grant_x ? x_addr  : c_addr;
                        wdata_q <= grant_x ? x_wdata : c_wdata;
                        cnt_q   <= LAT;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        if (cnt_q != 4'd0) begin
                            cnt_q <= cnt_q - 4'd1;
                        end else if (own_q) begin
                            x_rdata <= mem_rdata;
                        end else begin
                            c_rdata <= mem_rdata;
                        end
                    end
                end
                RESP: rr_last_q <= own_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random two-port traffic against
// a word-level memory model and a transaction-level reference of memory contents.
module tb_dmem_arbiter;

    localparam int AW     = 64;
    localparam int DW     = 64;
    localparam int RD_LAT = 3;
    localparam int WR_OWN = 2;
    localparam int RD_OWN = RD_LAT + 2;

    logic          CLK;
    logic          resetl;
    logic          c_req, c_we, x_req, x_we;
    logic [AW-1:0] c_addr, x_addr, mem_addr;
    logic [DW-1:0] c_wdata, x_wdata, c_rdata, x_rdata, mem_wdata, mem_rdata;
    logic          c_ack, x_ack, cpu_stall, mem_read, mem_write;
    logic [1:0]    dbg_state;

    dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .CLK(CLK), .resetl(resetl),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata), .cpu_stall(cpu_stall),
        .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
        .x_ack(x_ack), .x_rdata(x_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] ref_mem [16];
    logic [63:0] last_c_rd, last_x_rd;
    bit          last_served;  // 0 = C, 1 = X

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- DataMemory model ----------------
    logic [63:0] model [16];
    logic [15:0] rise_pipe = '0;
    logic [15:0] np;
    logic        rd_q = 1'b0;
    logic        rise;
    logic [3:0]  rd_idx = '0;
    logic [3:0]  a;

    // Read data is valid only RD_LAT cycles after mem_read rises; junk otherwise.
    initial begin
        for (int i = 0; i < 16; i++) begin
            model[i]   = '0;
            ref_mem[i] = '0;
        end
        mem_rdata = '0;
        forever begin
            @(posedge CLK);
            if (!resetl) begin
                rise_pipe <= '0;
                rd_q      <= 1'b0;
                mem_rdata <= '0;
            end else begin
                rise = mem_read & ~rd_q;
                np   = {rise_pipe[14:0], rise};
                a    = rise ? mem_addr[6:3] : rd_idx;
                rd_idx    <= a;
                rise_pipe <= np;
                rd_q      <= mem_read;
                if (mem_write) model[mem_addr[6:3]] <= mem_wdata;
                mem_rdata <= np[RD_LAT-1] ? model[a] : {$urandom, $urandom};
            end
        end
    end

    // ---------------- protocol monitor ----------------
    int   rd_run = 0;
    logic wr_prev = 1'b0, cack_prev = 1'b0, xack_prev = 1'b0;

    initial forever begin
        @(negedge CLK);
        if (!resetl) begin
            rd_run    = 0;
            wr_prev   = 1'b0;
            cack_prev = 1'b0;
            xack_prev = 1'b0;
        end else begin
            check("cpu_stall", 64'(cpu_stall), 64'(c_req & ~c_ack));
            if (mem_read || mem_write) check("strobe_excl", 64'(mem_read & mem_write), 0);
            if (mem_read) rd_run++;
            else if (rd_run != 0) begin
                check("rd_strobe_len", 64'(rd_run), 64'(RD_LAT));
                rd_run = 0;
            end
            if (mem_write) check("wr_strobe_len", 64'(wr_prev), 0);
            if (c_ack) check("c_ack_pulse", 64'(cack_prev), 0);
            if (x_ack) check("x_ack_pulse", 64'(xack_prev), 0);
            wr_prev   = mem_write;
            cack_prev = c_ack;
            xack_prev = x_ack;
        end
    end

    // ---------------- driver ----------------
    task automatic txn(input bit port, input logic we, input int idx, input logic [63:0] wd,
                       output int lat, output int done_cyc);
        logic [63:0] addr, rd, ev;
        int          n;
        bit          got;
        string       p;
        addr = 64'(idx) << 3;
        n    = 0;
        got  = 1'b0;
        p    = port ? "x" : "c";
        @(posedge CLK);
        #1;
        if (port) begin x_req = 1'b1; x_we = we; x_addr = addr; x_wdata = wd; end
        else      begin c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wd; end
        while (!got && n < 80) begin
            @(negedge CLK);
            n++;
            got = port ? x_ack : c_ack;
        end
        check({p, "_ack_seen"}, 64'(got), 1);
        lat      = n - 1;
        done_cyc = cyc;
        if (got) begin
            rd = port ? x_rdata : c_rdata;
            if (we) begin
                ref_mem[idx] = wd;
                check({p, "_rdata_hold"}, rd, port ? last_x_rd : last_c_rd);
            end else begin
                exp_q.push_back(ref_mem[idx]);
                ev = exp_q.pop_front();
                check({p, "_rdata"}, rd, ev);
                if (port) last_x_rd = ev; else last_c_rd = ev;
            end
            last_served = port;
        end
        @(posedge CLK);
        #1;
        if (port) x_req = 1'b0; else c_req = 1'b0;
    endtask

    task automatic do_reset();
        resetl = 1'b0;
        repeat (3) @(negedge CLK);
        resetl      = 1'b1;
        last_c_rd   = '0;
        last_x_rd   = '0;
        last_served = 1'b1;
    endtask

    task automatic tie(input string tag);
        int  cl, xl, cd, xd;
        bit  x_first;
        logic [63:0] cw, xw;
        x_first = (last_served == 1'b0);
        cw = {$urandom, $urandom};
        xw = {$urandom, $urandom};
        fork
            txn(1'b0, 1'b1, 1, cw, cl, cd);
            txn(1'b1, 1'b1, 2, xw, xl, xd);
        join
        check({tag, "_x_first"}, 64'(xd < cd), 64'(x_first));
        check({tag, "_c_lat"}, 64'(cl), x_first ? 64'(2 * WR_OWN + 1) : 64'(WR_OWN));
        check({tag, "_x_lat"}, 64'(xl), x_first ? 64'(WR_OWN) : 64'(2 * WR_OWN + 1));
    endtask

    // ---------------- stimulus ----------------
    int lat, dc, nack;
    logic [63:0] xr;

    initial begin
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        x_req = 0; x_we = 0; x_addr = '0; x_wdata = '0;
        last_c_rd = '0; last_x_rd = '0; last_served = 1'b1;
        do_reset();
        check("rst_c_ack", 64'(c_ack), 0);
        check("rst_x_ack", 64'(x_ack), 0);
        check("rst_mem_strobes", 64'({mem_read, mem_write}), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", c_rdata | x_rdata, 0);
        check("rst_state", 64'(dbg_state), 0);

        // C write then read-back at 0x40
        txn(1'b0, 1'b1, 8, 64'hDEAD_BEEF, lat, dc);
        check("c_wr_lat", 64'(lat), 64'(WR_OWN));
        txn(1'b0, 1'b0, 8, '0, lat, dc);
        check("c_rd_lat", 64'(lat), 64'(RD_OWN));
        check("c_rd_beef", c_rdata, 64'hDEAD_BEEF);

        // Reset in the middle of a read
        @(posedge CLK);
        #1 c_req = 1'b1; c_we = 1'b0; c_addr = 64'h40;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_mid_pre_read", 64'(mem_read), 1);
        #2 resetl = 1'b0;
        #1;
        check("rst_mid_mem_read", 64'(mem_read), 0);
        check("rst_mid_state", 64'(dbg_state), 0);
        check("rst_mid_c_ack", 64'(c_ack), 0);
        c_req = 1'b0;
        repeat (2) @(negedge CLK);
        resetl = 1'b1; last_c_rd = '0; last_x_rd = '0; last_served = 1'b1;
        nack = 0;
        repeat (8) begin
            @(negedge CLK);
            if (c_ack) nack++;
        end
        check("rst_mid_no_ack", 64'(nack), 0);
        check("rst_mid_rdata", c_rdata, 0);

        // Ties: winner follows who was served last
        tie("tie1");
        tie("tie2");
        txn(1'b0, 1'b1, 3, {$urandom, $urandom}, lat, dc);
        tie("tie3");

        // X back-to-back while C requests once
        fork
            begin
                int xl, xd;
                for (int i = 0; i < 5; i++) begin
                    txn(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), {$urandom, $urandom}, xl, xd);
                end
            end
            begin
                int cl, cd;
                repeat (4) @(posedge CLK);
                txn(1'b0, 1'b0, 8, '0, cl, cd);
                check("starve_c_bound", 64'(cl <= RD_OWN + RD_LAT + 3), 1);
            end
        join

        // X drops request during ACCESS; access still completes with one ack
        @(posedge CLK);
        #1 x_req = 1'b1; x_we = 1'b0; x_addr = 64'h40;
        @(negedge CLK);
        @(negedge CLK);
        check("xdrop_in_access", 64'(mem_read), 1);
        x_req = 1'b0;
        nack = 0; lat = 0; xr = '0;
        for (int i = 2; i < 20; i++) begin
            @(negedge CLK);
            if (x_ack) begin nack++; lat = i; xr = x_rdata; end
        end
        check("xdrop_ack_count", 64'(nack), 1);
        check("xdrop_ack_cycle", 64'(lat), 64'(RD_OWN));
        check("xdrop_rdata", xr, ref_mem[8]);
        last_x_rd = ref_mem[8];
        last_served = 1'b1;

        // Random two-port traffic
        fork
            for (int i = 0; i < 25; i++) begin
                int l, d, own;
                logic w;
                repeat ($urandom_range(0, 3)) @(posedge CLK);
                w   = 1'($urandom_range(0, 1));
                own = w ? WR_OWN : RD_OWN;
                txn(1'b0, w, $urandom_range(0, 15), {$urandom, $urandom}, l, d);
                check("rnd_c_lat_min", 64'(l >= own), 1);
                check("rnd_c_lat_max", 64'(l <= own + RD_LAT + 3), 1);
            end
            for (int i = 0; i < 25; i++) begin
                int l, d, own;
                logic w;
                repeat ($urandom_range(0, 3)) @(posedge CLK);
                w   = 1'($urandom_range(0, 1));
                own = w ? WR_OWN : RD_OWN;
                txn(1'b1, w, $urandom_range(0, 15), {$urandom, $urandom}, l, d);
                check("rnd_x_lat_min", 64'(l >= own), 1);
                check("rnd_x_lat_max", 64'(l <= own + RD_LAT + 3), 1);
            end
        join

        // Final read-back of every word through C
        for (int i = 0; i < 16; i++) txn(1'b0, 1'b0, i, '0, lat, dc);

        repeat (3) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
